// File: rtl/fetch_stage.sv
// Purpose: RV32I instruction-fetch stage; owns the PC, drives imem, fills the IF/ID register.
// Latency: PC to IF/ID is one cycle; a redirect puts its target on imem_addr the next cycle.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; flush/redirect insert a NOP bubble.
//
// Ports:
//   clock, reset            pipeline clock, synchronous active-high reset
//   imem_addr / imem_data   fetch address (registered PC) / combinational instruction word
//   stall                   hold PC and IF/ID
//   redirect_en/redirect_pc EX-resolved branch/jump target (low two bits dropped)
//   flush                   bubble the word entering IF/ID
//   if_id_pc/inst/valid     IF/ID pipeline register seen by decode
//   fetch_misalign          one-cycle pulse after a redirect to a non-word-aligned target
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched / perf_stall counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        fetch_misalign
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    logic [31:0] pc;
    logic        bubble;
    logic        load;

    // Redirect kills the wrong-path word fetched this cycle, so it bubbles like a flush.
    assign bubble = flush || redirect_en;
    assign load   = !bubble && !stall;

    assign imem_addr = pc;

    // Program counter: reset > redirect > stall > sequential (+4 wraps naturally at 2^32).
    always_ff @(posedge clock) begin
        if (reset) begin
            pc             <= RESET_PC;
            fetch_misalign <= 1'b0;
        end else begin
            fetch_misalign <= redirect_en && (redirect_pc[1:0] != 2'b00);
            if (redirect_en) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (!stall) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // IF/ID register: reset > flush/redirect > stall > load.
    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            if_id_pc    <= 32'd0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_pc    <= pc;
            if_id_inst  <= imem_data;
            if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Stall cycles are counted only when no redirect overrides them.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && !redirect_en) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: self-checking bench for fetch_stage (directed vector table plus randomized model run).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises stall, flush, redirect and their combinations.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        fetch_misalign;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign)
    );

    // Instruction memory: each word is a scrambled copy of its address.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3C3_3C3C;
    endfunction

    assign imem_data = tag(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [31:0] e_addr, input logic [31:0] e_pc,
                             input logic [31:0] e_inst, input logic e_vld, input logic e_mis);
        chk({name, ".imem_addr"},      imem_addr,             e_addr);
        chk({name, ".if_id_pc"},       if_id_pc,              e_pc);
        chk({name, ".if_id_inst"},     if_id_inst,            e_inst);
        chk({name, ".if_id_valid"},    {31'd0, if_id_valid},  {31'd0, e_vld});
        chk({name, ".fetch_misalign"}, {31'd0, fetch_misalign}, {31'd0, e_mis});
    endtask

    task automatic apply(input logic r, input logic s, input logic d, input logic [31:0] p,
                         input logic f);
        @(negedge clock);
        reset       = r;
        stall       = s;
        redirect_en = d;
        redirect_pc = p;
        flush       = f;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rde;
        logic [31:0] rpc;
        logic        fl;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_vld;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] p,
                                input logic f, input logic [31:0] ea, input logic [31:0] ep,
                                input logic ev, input logic em);
        vec_t v;
        v.rst = r; v.stl = s; v.rde = d; v.rpc = p; v.fl = f;
        v.e_addr = ea; v.e_pc = ep; v.e_vld = ev; v.e_mis = em;
        return v;
    endfunction

    vec_t vecs[22];

    // Reference model state: the architectural view after each edge.
    logic [31:0] m_pc, m_if_pc, m_if_inst;
    logic        m_vld, m_mis;

    task automatic model_edge(input logic r, input logic s, input logic d, input logic [31:0] p,
                              input logic f);
        logic [31:0] fetched_pc;
        fetched_pc = m_pc;
        if (r) begin
            m_pc = RESET_PC; m_mis = 1'b0;
            m_if_pc = 32'd0; m_if_inst = NOP_INST; m_vld = 1'b0;
        end else begin
            m_mis = d && (p % 4 != 0);
            if (d)       m_pc = p - (p % 4);
            else if (!s) m_pc = fetched_pc + 32'd4;
            if (f || d) begin
                m_if_pc = 32'd0; m_if_inst = NOP_INST; m_vld = 1'b0;
            end else if (!s) begin
                m_if_pc = fetched_pc; m_if_inst = tag(fetched_pc); m_vld = 1'b1;
            end
        end
    endtask

    initial begin
        // Directed sequence: each row is the input for one edge and the state expected after it.
        vecs[0]  = mk(1, 0, 0, 32'h0,          0, RESET_PC,       32'h0,          0, 0); // reset
        vecs[1]  = mk(0, 0, 0, 32'h0,          0, 32'h0100_0004,  32'h0100_0000,  1, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,          0, 32'h0100_0008,  32'h0100_0004,  1, 0);
        vecs[3]  = mk(0, 1, 0, 32'h0,          0, 32'h0100_0008,  32'h0100_0004,  1, 0); // stall x3
        vecs[4]  = mk(0, 1, 0, 32'h0,          0, 32'h0100_0008,  32'h0100_0004,  1, 0);
        vecs[5]  = mk(0, 1, 0, 32'h0,          0, 32'h0100_0008,  32'h0100_0004,  1, 0);
        vecs[6]  = mk(0, 0, 0, 32'h0,          0, 32'h0100_000C,  32'h0100_0008,  1, 0);
        vecs[7]  = mk(0, 0, 0, 32'h0,          0, 32'h0100_0010,  32'h0100_000C,  1, 0);
        vecs[8]  = mk(0, 0, 1, 32'h0100_0040,  0, 32'h0100_0040,  32'h0,          0, 0); // redirect
        vecs[9]  = mk(0, 0, 0, 32'h0,          0, 32'h0100_0044,  32'h0100_0040,  1, 0);
        vecs[10] = mk(0, 1, 1, 32'h0100_0080,  0, 32'h0100_0080,  32'h0,          0, 0); // redirect+stall
        vecs[11] = mk(0, 0, 0, 32'h0,          0, 32'h0100_0084,  32'h0100_0080,  1, 0);
        vecs[12] = mk(0, 0, 1, 32'h0100_0042,  0, 32'h0100_0040,  32'h0,          0, 1); // misaligned
        vecs[13] = mk(0, 0, 0, 32'h0,          0, 32'h0100_0044,  32'h0100_0040,  1, 0);
        vecs[14] = mk(0, 0, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,  32'h0,          0, 0);
        vecs[15] = mk(0, 0, 0, 32'h0,          0, 32'h0000_0000,  32'hFFFF_FFFC,  1, 0); // wrap
        vecs[16] = mk(0, 0, 0, 32'h0,          0, 32'h0000_0004,  32'h0000_0000,  1, 0);
        vecs[17] = mk(0, 1, 0, 32'h0,          0, 32'h0000_0004,  32'h0000_0000,  1, 0);
        vecs[18] = mk(1, 1, 0, 32'h0,          0, RESET_PC,       32'h0,          0, 0); // reset mid-stall
        vecs[19] = mk(0, 0, 0, 32'h0,          1, 32'h0100_0004,  32'h0,          0, 0); // flush
        vecs[20] = mk(0, 1, 0, 32'h0,          1, 32'h0100_0004,  32'h0,          0, 0); // flush+stall
        vecs[21] = mk(0, 0, 0, 32'h0,          0, 32'h0100_0008,  32'h0100_0004,  1, 0);

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i].rst, vecs[i].stl, vecs[i].rde, vecs[i].rpc, vecs[i].fl);
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc,
                      vecs[i].e_vld ? tag(vecs[i].e_pc) : NOP_INST, vecs[i].e_vld, vecs[i].e_mis);
        end

        // Hand sequence: back-to-back misaligned redirects keep the flag up, then it drops.
        apply(0, 0, 1, 32'h0000_1001, 0);
        check_all("mis_a", 32'h0000_1000, 32'h0, NOP_INST, 0, 1);
        apply(0, 0, 1, 32'h0000_2003, 0);
        check_all("mis_b", 32'h0000_2000, 32'h0, NOP_INST, 0, 1);
        apply(0, 1, 0, 32'h0000_3003, 0);
        check_all("mis_c", 32'h0000_2000, 32'h0, NOP_INST, 0, 0);

        // Randomized run against the reference model, starting from reset.
        m_pc = 32'd0; m_if_pc = 32'd0; m_if_inst = 32'd0; m_vld = 1'b0; m_mis = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        r, s, d, f;
            logic [31:0] p;
            r = (c == 0) || ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
            model_edge(r, s, d, p, f);
            apply(r, s, d, p, f);
            check_all($sformatf("rnd%0d", c), m_pc, m_if_pc, m_if_inst, m_vld, m_mis);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
